// File: rtl/power_analyzer_pkg.sv
// Shared types and width helpers for the power window analyzer.
// The state encoding and counter width rules are used by the top and the bench.
package power_analyzer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_WINDOW     = 48000;
   localparam int DEF_DECIM      = 4800;

   // Wide enough for WINDOW full-scale squares without wrapping.
   function automatic int acc_width(input int data_width, input int window);
      return 2 * data_width + $clog2(window);
   endfunction

   // Counter holding 0..count-1; a one-state counter still needs one bit.
   function automatic int cnt_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/signed_squarer.sv
// Registered two's-complement square with valid and tag carried alongside.
// The product is non-negative, so it is presented as an unsigned 2*DATA_WIDTH value.
module signed_squarer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_tag,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      out_valid,
   output logic                      out_tag,
   output logic [2*DATA_WIDTH-1:0]   out_square
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   logic [PROD_W-1:0] w_ext;
   logic [PROD_W-1:0] w_prod;
   logic              r_valid;
   logic              r_tag;
   logic [PROD_W-1:0] r_square;

   // Sign extension makes the truncated unsigned product equal the exact square.
   assign w_ext  = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
   assign w_prod = w_ext * w_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid  <= 1'b0;
         r_tag    <= 1'b0;
         r_square <= '0;
      end else begin
         r_valid <= in_valid;
         r_tag   <= in_valid & in_tag;
         if (in_valid) begin
            r_square <= w_prod;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_tag    = r_tag;
   assign out_square = r_square;

endmodule

// File: rtl/power_window_analyzer.sv
// Sum-of-squares over a fixed sample window, plus the same sum over every DECIM-th sample.
// Results are offered through a valid/ready handshake and held until the next start.
module power_window_analyzer
   import power_analyzer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WINDOW     = DEF_WINDOW,
   parameter int DECIM      = DEF_DECIM,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, WINDOW)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  busy,
   output logic [ACC_WIDTH-1:0]  total_power,
   output logic [ACC_WIDTH-1:0]  decim_power,
   output logic                  result_valid,
   input  logic                  result_ready
);

   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int CNT_W  = cnt_width(WINDOW);
   localparam int DEC_W  = cnt_width(DECIM);

   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW - 1);
   localparam logic [DEC_W-1:0] LAST_DECIM  = DEC_W'(DECIM - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_sample_cnt;
   logic [DEC_W-1:0]   r_decim_cnt;
   logic [ACC_WIDTH-1:0] r_total;
   logic [ACC_WIDTH-1:0] r_decim;
   logic               r_busy;
   logic               r_result_valid;

   logic               w_accept;
   logic               w_tag;
   logic               w_sq_valid;
   logic               w_sq_tag;
   logic [PROD_W-1:0]  w_sq;
   logic [ACC_WIDTH-1:0] w_sq_ext;

   assign w_accept = (r_state == ACCUM) && sample_valid;
   assign w_tag    = (r_decim_cnt == '0);
   assign w_sq_ext = {{(ACC_WIDTH - PROD_W){1'b0}}, w_sq};

   signed_squarer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_squarer (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (w_accept),
      .in_tag     (w_tag),
      .in_data    (sample_in),
      .out_valid  (w_sq_valid),
      .out_tag    (w_sq_tag),
      .out_square (w_sq)
   );

   // Stage 2 accumulation runs alongside the FSM; the DRAIN cycle lets the
   // last registered square land before the result is flagged valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_sample_cnt   <= '0;
         r_decim_cnt    <= '0;
         r_total        <= '0;
         r_decim        <= '0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         if (w_sq_valid) begin
            r_total <= r_total + w_sq_ext;
            if (w_sq_tag) begin
               r_decim <= r_decim + w_sq_ext;
            end
         end

         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state      <= ACCUM;
                  r_busy       <= 1'b1;
                  r_sample_cnt <= '0;
                  r_decim_cnt  <= '0;
                  r_total      <= '0;
                  r_decim      <= '0;
               end
            end

            ACCUM: begin
               if (sample_valid) begin
                  r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                  if (r_decim_cnt == LAST_DECIM) begin
                     r_decim_cnt <= '0;
                  end else begin
                     r_decim_cnt <= r_decim_cnt + DEC_W'(1);
                  end
                  if (r_sample_cnt == LAST_SAMPLE) begin
                     r_state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               r_state        <= DONE;
               r_busy         <= 1'b0;
               r_result_valid <= 1'b1;
            end

            DONE: begin
               if (result_ready) begin
                  r_state        <= IDLE;
                  r_result_valid <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign total_power  = r_total;
   assign decim_power  = r_decim;

endmodule

// File: tb/tb_power_window_analyzer.sv
// Scoreboard bench: three analyzer configurations share clock and reset; expected
// sums are computed from the stimulus by a 64-bit integer model and queued.
module tb_power_window_analyzer;

   localparam int DW = 32;
   localparam int AW = 80;

   typedef struct packed {
      logic [AW-1:0] total;
      logic [AW-1:0] decim;
   } result_t;

   logic          clk;
   logic          rst;
   logic          startS      [3];
   logic          sampleValid [3];
   logic          resultReady [3];
   logic          busy        [3];
   logic          resultValid [3];
   logic [DW-1:0] sampleIn    [3];
   logic [AW-1:0] totalPower  [3];
   logic [AW-1:0] decimPower  [3];

   int checks   = 0;
   int failures = 0;

   result_t               expQ [$];
   logic signed [DW-1:0]  stimQ [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   power_window_analyzer #(.DATA_WIDTH(DW), .WINDOW(10), .DECIM(4), .ACC_WIDTH(AW)) dutA (
      .clk(clk), .rst(rst), .start(startS[0]), .sample_in(sampleIn[0]),
      .sample_valid(sampleValid[0]), .busy(busy[0]), .total_power(totalPower[0]),
      .decim_power(decimPower[0]), .result_valid(resultValid[0]), .result_ready(resultReady[0])
   );

   power_window_analyzer #(.DATA_WIDTH(DW), .WINDOW(4), .DECIM(2), .ACC_WIDTH(AW)) dutB (
      .clk(clk), .rst(rst), .start(startS[1]), .sample_in(sampleIn[1]),
      .sample_valid(sampleValid[1]), .busy(busy[1]), .total_power(totalPower[1]),
      .decim_power(decimPower[1]), .result_valid(resultValid[1]), .result_ready(resultReady[1])
   );

   power_window_analyzer #(.DATA_WIDTH(DW), .WINDOW(3), .DECIM(1), .ACC_WIDTH(AW)) dutC (
      .clk(clk), .rst(rst), .start(startS[2]), .sample_in(sampleIn[2]),
      .sample_valid(sampleValid[2]), .busy(busy[2]), .total_power(totalPower[2]),
      .decim_power(decimPower[2]), .result_valid(resultValid[2]), .result_ready(resultReady[2])
   );

   function automatic logic [AW-1:0] modelSq(input logic signed [DW-1:0] x);
      longint v;
      longint p;
      v = longint'(x);
      p = v * v;
      return {16'd0, p};
   endfunction

   // Queue the expected sums, then start the window and feed stimQ; optional idle gaps.
   task automatic applyStimulus(input int d, input int decim, input bit gaps, output int busyDrops);
      result_t e;
      e.total   = '0;
      e.decim   = '0;
      busyDrops = 0;
      for (int i = 0; i < stimQ.size(); i++) begin
         e.total += modelSq(stimQ[i]);
         if (i % decim == 0) e.decim += modelSq(stimQ[i]);
      end
      expQ.push_back(e);
      @(posedge clk); #1 startS[d] = 1'b1;
      @(posedge clk); #1 startS[d] = 1'b0;
      while (stimQ.size() > 0) begin
         sampleIn[d]    = stimQ.pop_front();
         sampleValid[d] = 1'b1;
         @(posedge clk); #1;
         sampleValid[d] = 1'b0;
         if (gaps && stimQ.size() > 0) begin
            sampleIn[d] = $urandom;
            @(posedge clk); #1;
            if (busy[d] !== 1'b1) busyDrops++;
         end
      end
   endtask

   task automatic waitValid(input int d, input int maxCycles, output int cycles);
      cycles = 0;
      while (resultValid[d] !== 1'b1 && cycles < maxCycles) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic popExpected(output result_t e);
      e = '0;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_empty: got empty queue, required an entry");
      end else begin
         e = expQ.pop_front();
      end
   endtask

   task automatic ackResult(input int d);
      resultReady[d] = 1'b1;
      @(posedge clk); #1;
      resultReady[d] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (busy[d] !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_busy[%0d]: got %b required 0", d, busy[d]);
         end
         checks++;
         if (resultValid[d] !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_valid[%0d]: got %b required 0", d, resultValid[d]);
         end
         checks++;
         if (totalPower[d] !== '0) begin
            failures++; $display("[TB] FAIL reset_total[%0d]: got %0h required 0", d, totalPower[d]);
         end
         checks++;
         if (decimPower[d] !== '0) begin
            failures++; $display("[TB] FAIL reset_decim[%0d]: got %0h required 0", d, decimPower[d]);
         end
      end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_continuous;
      int drops, cyc;
      result_t e;
      for (int i = 1; i <= 10; i++) stimQ.push_back(i);
      applyStimulus(0, 4, 1'b0, drops);
      waitValid(0, 10, cyc);
      checks++;
      if (cyc !== 1) begin
         failures++; $display("[TB] FAIL cont_latency: got %0d edges after last sample, required 1", cyc);
      end
      popExpected(e);
      checks++;
      if (totalPower[0] !== e.total) begin
         failures++; $display("[TB] FAIL cont_total: got %0d required %0d", totalPower[0], e.total);
      end
      checks++;
      if (decimPower[0] !== e.decim) begin
         failures++; $display("[TB] FAIL cont_decim: got %0d required %0d", decimPower[0], e.decim);
      end
      checks++;
      if (busy[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL cont_busy_done: got %b required 0", busy[0]);
      end
      ackResult(0);
      checks++;
      if (resultValid[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL cont_valid_drop: got %b required 0", resultValid[0]);
      end
   endtask

   task automatic test_gaps;
      int drops, cyc;
      result_t e;
      for (int i = 1; i <= 10; i++) stimQ.push_back(i);
      applyStimulus(0, 4, 1'b1, drops);
      checks++;
      if (drops !== 0) begin
         failures++; $display("[TB] FAIL gaps_busy: got %0d gap cycles with busy low, required 0", drops);
      end
      waitValid(0, 10, cyc);
      popExpected(e);
      checks++;
      if (resultValid[0] !== 1'b1 || totalPower[0] !== e.total) begin
         failures++; $display("[TB] FAIL gaps_total: got %0d (valid %b) required %0d", totalPower[0], resultValid[0], e.total);
      end
      checks++;
      if (decimPower[0] !== e.decim) begin
         failures++; $display("[TB] FAIL gaps_decim: got %0d required %0d", decimPower[0], e.decim);
      end
      ackResult(0);
   endtask

   task automatic test_most_negative;
      int drops, cyc;
      result_t e;
      for (int i = 0; i < 4; i++) stimQ.push_back(32'sh8000_0000);
      applyStimulus(1, 2, 1'b0, drops);
      waitValid(1, 10, cyc);
      popExpected(e);
      checks++;
      if (resultValid[1] !== 1'b1 || totalPower[1] !== e.total) begin
         failures++; $display("[TB] FAIL neg_total: got %0h (valid %b) required %0h", totalPower[1], resultValid[1], e.total);
      end
      checks++;
      if (totalPower[1] !== 80'h1_0000_0000_0000_0000) begin
         failures++; $display("[TB] FAIL neg_total_2pow64: got %0h required 10000000000000000", totalPower[1]);
      end
      checks++;
      if (decimPower[1] !== 80'h0_8000_0000_0000_0000) begin
         failures++; $display("[TB] FAIL neg_decim_2pow63: got %0h required 8000000000000000", decimPower[1]);
      end
      ackResult(1);
   endtask

   task automatic test_stall;
      int drops, cyc;
      result_t e;
      for (int i = 0; i < 10; i++) stimQ.push_back($urandom);
      applyStimulus(0, 4, 1'b0, drops);
      waitValid(0, 10, cyc);
      popExpected(e);
      for (int c = 0; c < 20; c++) begin
         startS[0]      = c[0];
         sampleValid[0] = 1'b1;
         sampleIn[0]    = $urandom;
         @(posedge clk); #1;
         checks++;
         if (resultValid[0] !== 1'b1) begin
            failures++; $display("[TB] FAIL stall_valid c%0d: got %b required 1", c, resultValid[0]);
         end
         checks++;
         if (totalPower[0] !== e.total) begin
            failures++; $display("[TB] FAIL stall_total c%0d: got %0h required %0h", c, totalPower[0], e.total);
         end
         checks++;
         if (decimPower[0] !== e.decim) begin
            failures++; $display("[TB] FAIL stall_decim c%0d: got %0h required %0h", c, decimPower[0], e.decim);
         end
      end
      startS[0]      = 1'b0;
      sampleValid[0] = 1'b0;
      ackResult(0);
      checks++;
      if (resultValid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL stall_release: got valid %b busy %b required 0 0", resultValid[0], busy[0]);
      end
      checks++;
      if (totalPower[0] !== e.total) begin
         failures++; $display("[TB] FAIL stall_hold_after: got %0h required %0h", totalPower[0], e.total);
      end
   endtask

   task automatic test_abort;
      int drops, cyc;
      result_t e;
      @(posedge clk); #1 startS[0] = 1'b1;
      @(posedge clk); #1 startS[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sampleIn[0]    = 32'd7;
         sampleValid[0] = 1'b1;
         @(posedge clk); #1;
      end
      sampleValid[0] = 1'b0;
      @(negedge clk) rst = 1'b0;
      #1;
      checks++;
      if (busy[0] !== 1'b0 || resultValid[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL abort_flags: got busy %b valid %b required 0 0", busy[0], resultValid[0]);
      end
      checks++;
      if (totalPower[0] !== '0 || decimPower[0] !== '0) begin
         failures++; $display("[TB] FAIL abort_clear: got %0d/%0d required 0/0", totalPower[0], decimPower[0]);
      end
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 10; i++) stimQ.push_back(32'sd2);
      applyStimulus(0, 4, 1'b0, drops);
      waitValid(0, 10, cyc);
      popExpected(e);
      checks++;
      if (resultValid[0] !== 1'b1 || totalPower[0] !== e.total) begin
         failures++; $display("[TB] FAIL abort_total: got %0d (valid %b) required %0d", totalPower[0], resultValid[0], e.total);
      end
      checks++;
      if (decimPower[0] !== e.decim) begin
         failures++; $display("[TB] FAIL abort_decim: got %0d required %0d", decimPower[0], e.decim);
      end
      ackResult(0);
   endtask

   task automatic test_back_to_back;
      int drops, cyc;
      result_t e;
      stimQ.push_back(32'sd3);
      stimQ.push_back(-32'sd4);
      stimQ.push_back(32'sd5);
      applyStimulus(2, 1, 1'b0, drops);
      waitValid(2, 10, cyc);
      popExpected(e);
      checks++;
      if (resultValid[2] !== 1'b1 || totalPower[2] !== e.total) begin
         failures++; $display("[TB] FAIL b2b_total1: got %0d (valid %b) required %0d", totalPower[2], resultValid[2], e.total);
      end
      checks++;
      if (decimPower[2] !== e.decim) begin
         failures++; $display("[TB] FAIL b2b_decim1: got %0d required %0d", decimPower[2], e.decim);
      end
      ackResult(2);
      checks++;
      if (resultValid[2] !== 1'b0) begin
         failures++; $display("[TB] FAIL b2b_valid_drop: got %b required 0", resultValid[2]);
      end
      stimQ.push_back(-32'sd1);
      stimQ.push_back(32'sd0);
      stimQ.push_back(32'sd2);
      applyStimulus(2, 1, 1'b0, drops);
      waitValid(2, 10, cyc);
      popExpected(e);
      checks++;
      if (resultValid[2] !== 1'b1 || totalPower[2] !== e.total) begin
         failures++; $display("[TB] FAIL b2b_total2: got %0d (valid %b) required %0d", totalPower[2], resultValid[2], e.total);
      end
      checks++;
      if (decimPower[2] !== e.decim) begin
         failures++; $display("[TB] FAIL b2b_decim2: got %0d required %0d", decimPower[2], e.decim);
      end
      ackResult(2);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         startS[d]      = 1'b0;
         sampleValid[d] = 1'b0;
         resultReady[d] = 1'b0;
         sampleIn[d]    = '0;
      end
      #2;
      test_reset;
      test_continuous;
      test_gaps;
      test_most_negative;
      test_stall;
      test_abort;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
